// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: drives rows one-cold, samples columns into a
// 12-bit frame, debounces whole frames and decodes a one-hot digit.
`timescale 1ns/1ps
module keypad_scan #(
  parameter int ROW_HOLD       = 2,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic       multi_key,
  output logic       key_valid
);

  localparam logic [3:0] SC_LAST = 4'(ROW_HOLD - 1);
  localparam logic [3:0] DB_MAX  = 4'(DEBOUNCE_SCANS);

  logic [3:0]  sc_q, sc_d;
  logic [1:0]  r_q, r_d;
  logic [3:0]  row_q, row_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] last_q, last_d;
  logic [11:0] stable_q, stable_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  kp_q, kp_d;
  logic        star_q, star_d;
  logic        hash_q, hash_d;
  logic        multi_q, multi_d;
  logic        valid_q, valid_d;

  logic        sample;
  logic [11:0] frame;
  logic [3:0]  ones;

  // Scan sequencing, frame accumulation and debounce.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    sample   = (sc_q == SC_LAST);
    sc_d     = sample ? 4'd0 : sc_q + 4'd1;
    r_d      = sample ? r_q + 2'd1 : r_q;
    row_d    = ~(4'b0001 << r_d);
    frame    = acc_q;
    acc_d    = acc_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;

    case (r_q)
      2'd0:    frame[2:0]  = ~key_col;
      2'd1:    frame[5:3]  = ~key_col;
      2'd2:    frame[8:6]  = ~key_col;
      default: frame[11:9] = ~key_col;
    endcase

    if (sample) begin
      acc_d = frame;
      if (r_q == 2'd3) begin
        if (frame == last_q) begin
          if (cnt_q < DB_MAX) cnt_d = cnt_q + 4'd1;
        end else begin
          last_d = frame;
          cnt_d  = 4'd1;
        end
        // Re-committing on every later matching frame leaves stable unchanged.
        if (cnt_d == DB_MAX) stable_d = frame;
      end
    end
  end

  // Decode of the debounced frame; bit 3*row+col maps onto the phone layout.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 12; i++) ones = ones + 4'(stable_q[i]);

    kp_d    = '0;
    star_d  = 1'b0;
    hash_d  = 1'b0;
    multi_d = 1'b0;
    if (ones > 4'd1) begin
      multi_d = 1'b1;
    end else if (ones == 4'd1) begin
      kp_d   = {stable_q[8:0], stable_q[10]};
      star_d = stable_q[9];
      hash_d = stable_q[11];
    end

    // Pulse only when a single key appears that differs from what is shown now.
    valid_d = (|{kp_d, star_d, hash_d}) &&
              ({kp_d, star_d, hash_d} != {kp_q, star_q, hash_q});
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      sc_q     <= '0;
      r_q      <= '0;
      row_q    <= 4'b1110;
      acc_q    <= '0;
      last_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      kp_q     <= '0;
      star_q   <= 1'b0;
      hash_q   <= 1'b0;
      multi_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      r_q      <= r_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      kp_q     <= kp_d;
      star_q   <= star_d;
      hash_q   <= hash_d;
      multi_q  <= multi_d;
      valid_q  <= valid_d;
    end
  end

  assign key_row   = row_q;
  assign keypad    = kp_q;
  assign key_star  = star_q;
  assign key_hash  = hash_q;
  assign multi_key = multi_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a key-matrix model closes switches from a
// 12-bit "pressed" mask; expected outputs and latencies are hand-computed.
`timescale 1ns/1ps
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [9:0]  keypad;
  logic        key_star, key_hash, multi_key, key_valid;

  logic [11:0] pressed;
  int          cyc;
  int          n_checks = 0;
  int          n_err    = 0;
  int          vcount;
  logic        kp_seen;
  logic [12:0] outs;

  typedef struct {
    logic [11:0] press;
    logic [12:0] exp_outs;   // {keypad, key_star, key_hash, multi_key}
    logic        exp_valid;
  } vec_t;

  vec_t vecs [13];

  keypad_scan dut (
    .clk       (clk),
    .rst       (rst),
    .key_col   (key_col),
    .key_row   (key_row),
    .keypad    (keypad),
    .key_star  (key_star),
    .key_hash  (key_hash),
    .multi_key (multi_key),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  assign outs = {keypad, key_star, key_hash, multi_key};

  // Switch matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = 3'b111;
    if (!key_row[0]) key_col = key_col & ~pressed[2:0];
    if (!key_row[1]) key_col = key_col & ~pressed[5:3];
    if (!key_row[2]) key_col = key_col & ~pressed[8:6];
    if (!key_row[3]) key_col = key_col & ~pressed[11:9];
  end

  // Active cycles since reset release; frame starts where cyc % 8 == 0.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_valid) vcount++;
      if (keypad != 10'd0) kp_seen = 1'b1;
    end
  endtask

  task automatic wait_frame();
    @(negedge clk);
    for (int i = 0; i < 8 && (cyc % 8) != 0; i++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] row_exp [8];
    vecs[0]  = '{12'h001, {10'b0000000010, 3'b000}, 1'b1};
    vecs[1]  = '{12'h002, {10'b0000000100, 3'b000}, 1'b1};
    vecs[2]  = '{12'h004, {10'b0000001000, 3'b000}, 1'b1};
    vecs[3]  = '{12'h008, {10'b0000010000, 3'b000}, 1'b1};
    vecs[4]  = '{12'h010, {10'b0000100000, 3'b000}, 1'b1};
    vecs[5]  = '{12'h020, {10'b0001000000, 3'b000}, 1'b1};
    vecs[6]  = '{12'h040, {10'b0010000000, 3'b000}, 1'b1};
    vecs[7]  = '{12'h080, {10'b0100000000, 3'b000}, 1'b1};
    vecs[8]  = '{12'h100, {10'b1000000000, 3'b000}, 1'b1};
    vecs[9]  = '{12'h200, {10'b0000000000, 3'b100}, 1'b1};
    vecs[10] = '{12'h400, {10'b0000000001, 3'b000}, 1'b1};
    vecs[11] = '{12'h800, {10'b0000000000, 3'b010}, 1'b1};
    vecs[12] = '{12'h090, {10'b0000000000, 3'b001}, 1'b0};
    row_exp = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};

    // Reset and row stepping
    rst = 1'b0;
    pressed = '0;
    vcount = 0;
    kp_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_row", 32'(key_row), 32'(4'b1110));
      check("reset_outs", 32'({outs, key_valid}), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("row_step", 32'(key_row), 32'(row_exp[i]));
      check("idle_outs", 32'({outs, key_valid}), 32'd0);
    end
    advance(24);
    check("idle_settled", 32'({outs, key_valid}), 32'd0);

    // Every single key, plus a two-key frame
    for (int v = 0; v < 13; v++) begin
      wait_frame();
      pressed = vecs[v].press;
      vcount = 0;
      advance(24);
      check("press_early", 32'(outs), 32'd0);
      advance(1);
      check("press_outs", 32'(outs), 32'(vecs[v].exp_outs));
      check("press_valid", 32'(key_valid), 32'(vecs[v].exp_valid));
      advance(23);
      check("press_hold", 32'(outs), 32'(vecs[v].exp_outs));
      check("press_pulses", vcount, 32'(vecs[v].exp_valid));
      pressed = '0;
      vcount = 0;
      advance(24);
      check("release_early", 32'(outs), 32'(vecs[v].exp_outs));
      advance(1);
      check("release_outs", 32'(outs), 32'd0);
      advance(8);
      check("release_pulses", vcount, 32'd0);
    end

    // Bounce on digit 0 for six frames, then held
    wait_frame();
    vcount = 0;
    kp_seen = 1'b0;
    for (int f = 0; f < 6; f++) begin
      pressed = (f % 2 == 0) ? 12'h400 : 12'h000;
      advance(8);
    end
    pressed = 12'h400;
    advance(24);
    check("bounce_quiet", 32'({kp_seen, outs}), 32'd0);
    advance(1);
    check("bounce_keypad", 32'(keypad), 32'(10'b0000000001));
    check("bounce_valid", 32'(key_valid), 32'd1);
    advance(8);
    check("bounce_pulses", vcount, 32'd1);
    wait_frame();
    pressed = '0;
    advance(40);
    check("bounce_release", 32'(outs), 32'd0);

    // Multi-key 1+9, then release 9
    wait_frame();
    pressed = 12'h101;
    vcount = 0;
    advance(25);
    check("multi_outs", 32'(outs), 32'(13'b0000000000_001));
    advance(7);
    check("multi_pulses", vcount, 32'd0);
    pressed = 12'h001;
    advance(24);
    check("multi_hold", 32'(multi_key), 32'd1);
    advance(1);
    check("multi_to_one", 32'(outs), 32'(13'b0000000010_000));
    check("multi_to_one_valid", 32'(key_valid), 32'd1);
    advance(7);
    pressed = '0;
    advance(40);
    check("multi_release", 32'(outs), 32'd0);

    // Star, then direct swap to hash
    wait_frame();
    pressed = 12'h200;
    vcount = 0;
    advance(25);
    check("star_outs", 32'(outs), 32'(13'b0000000000_100));
    check("star_valid", 32'(key_valid), 32'd1);
    advance(7);
    pressed = 12'h800;
    advance(24);
    check("swap_early", 32'(outs), 32'(13'b0000000000_100));
    advance(1);
    check("hash_outs", 32'(outs), 32'(13'b0000000000_010));
    check("hash_valid", 32'(key_valid), 32'd1);
    advance(7);
    pressed = '0;
    advance(40);
    check("hash_release", 32'(outs), 32'd0);
    check("star_hash_pulses", vcount, 32'd2);

    // Mid-frame reset with 7 debounced
    wait_frame();
    pressed = 12'h040;
    advance(25);
    check("seven_before_reset", 32'(keypad), 32'(10'b0010000000));
    advance(3);
    check("at_row2", 32'(key_row), 32'(4'b1011));
    rst = 1'b0;
    advance(1);
    check("midreset_outs", 32'({outs, key_valid}), 32'd0);
    check("midreset_row", 32'(key_row), 32'(4'b1110));
    rst = 1'b1;
    vcount = 0;
    advance(24);
    check("after_reset_early", 32'(outs), 32'd0);
    advance(1);
    check("after_reset_keypad", 32'(keypad), 32'(10'b0010000000));
    check("after_reset_valid", 32'(key_valid), 32'd1);
    pressed = '0;
    advance(8);
    check("after_reset_pulses", vcount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
